inst_queue: RTL and testbench

- Instruction queue on the consumer end of the instruction-memory stage's valid/ready output.
- Accepts {pc, inst} beats from the instruction-memory stage and buffers up to DEPTH entries.
- Presents entries in order to the decode stage over a registered valid/ready interface.
- Supports single-cycle flush on branch taken; decouples decode stalls from fetch.

---
 rtl/inst_queue.sv | 112 +++++++++++
 tb/tb_inst_queue.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
// Instruction queue between the instruction-memory stage and decode.
// Holds up to DEPTH {pc, inst} beats and presents the oldest through registered head outputs.
module inst_queue #(
  parameter int          DEPTH = 4,
  parameter int          AW    = 2,
  parameter logic [31:0] NOP   = 32'h00000013
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [31:0]   pc_i,
  input  logic [31:0]   inst_i,
  input  logic          flush_i,
  output logic          valid_ro,
  input  logic          ready_i,
  output logic [31:0]   pc_ro,
  output logic [31:0]   inst_ro,
  output logic          illegal_ro,
  output logic [AW:0]   count_o
);

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        illegal;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] rd_next;
  logic [AW:0]   count_q, count_d;
  logic [AW:0]   avail;
  logic          valid_ro_q, valid_ro_d;
  logic [31:0]   pc_ro_q, pc_ro_d;
  logic [31:0]   inst_ro_q, inst_ro_d;
  logic          illegal_ro_q, illegal_ro_d;
  logic          push, pop;

  assign ready_o = (count_q != CNT_FULL);
  assign push    = valid_i && ready_o;
  assign pop     = valid_ro_q && ready_i;

  always_comb begin
    mem_d = mem_q;
    if (push && !flush_i) begin
      mem_d[wr_ptr_q] = '{pc: pc_i, inst: inst_i, illegal: (inst_i[1:0] != 2'b11)};
    end

    rd_next  = rd_ptr_q + AW'(pop);
    // Only entries already in storage before this edge may reach the head,
    // which gives the one-cycle push-to-head latency with no bypass.
    avail    = count_q - (AW+1)'(pop);
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_next;
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);

    valid_ro_d   = (avail != '0);
    pc_ro_d      = pc_ro_q;
    inst_ro_d    = NOP;
    illegal_ro_d = 1'b0;
    if (avail != '0) begin
      pc_ro_d      = mem_q[rd_next].pc;
      inst_ro_d    = mem_q[rd_next].inst;
      illegal_ro_d = mem_q[rd_next].illegal;
    end

    if (flush_i) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      valid_ro_d   = 1'b0;
      inst_ro_d    = NOP;
      illegal_ro_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      valid_ro_q   <= 1'b0;
      pc_ro_q      <= '0;
      inst_ro_q    <= NOP;
      illegal_ro_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      valid_ro_q   <= valid_ro_d;
      pc_ro_q      <= pc_ro_d;
      inst_ro_q    <= inst_ro_d;
      illegal_ro_q <= illegal_ro_d;
    end
  end

  assign valid_ro   = valid_ro_q;
  assign pc_ro      = pc_ro_q;
  assign inst_ro    = inst_ro_q;
  assign illegal_ro = illegal_ro_q;
  assign count_o    = count_q;

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: accepted beats are queued and compared in order as decode pops them.
module tb_inst_queue;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] pc_i = '0;
  logic [31:0] inst_i = NOP;
  logic        flush_i = 1'b0;
  logic        valid_ro;
  logic        ready_i = 1'b0;
  logic [31:0] pc_ro;
  logic [31:0] inst_ro;
  logic        illegal_ro;
  logic [2:0]  count_o;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];
  logic [63:0] exp;
  logic        exp_ill;
  bit          acc;

  inst_queue #(.DEPTH(4), .AW(2), .NOP(NOP)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .pc_i(pc_i),
    .inst_i(inst_i), .flush_i(flush_i), .valid_ro(valid_ro), .ready_i(ready_i),
    .pc_ro(pc_ro), .inst_ro(inst_ro), .illegal_ro(illegal_ro), .count_o(count_o)
  );

  always #5 clk = ~clk;

  // Advance one edge; records the beat into the scoreboard if it is accepted.
  task automatic tick(output bit accepted);
    accepted = valid_i && ready_o && rst && !flush_i;
    if (!rst || flush_i) sb.delete();
    else if (accepted) sb.push_back({pc_i, inst_i});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(acc);
    tick(acc);
    rst = 1'b1;
    checks++; if (valid_ro !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_ro); end
    checks++; if (pc_ro !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", pc_ro); end
    checks++; if (inst_ro !== NOP) begin errors++; $display("FAIL reset_inst got %h want %h", inst_ro, NOP); end
    checks++; if (illegal_ro !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b want 0", illegal_ro); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready_o); end
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count_o); end
  endtask

  task automatic test_stream();
    int first_valid = -1;
    int first_pop = -1;
    int last_pop = -1;
    int npop = 0;
    ready_i = 1'b1;
    for (int c = 0; c < 12; c++) begin
      valid_i = (c < 4);
      pc_i    = 32'(c * 4);
      inst_i  = NOP;
      if (valid_ro && first_valid < 0) first_valid = c;
      if (valid_ro && ready_i) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL stream_extra pop pc=%h", pc_ro); end
        else begin
          exp = sb.pop_front(); exp_ill = (exp[1:0] != 2'b11);
          if ({pc_ro, inst_ro, illegal_ro} !== {exp, exp_ill}) begin
            errors++; $display("FAIL stream_order got pc=%h inst=%h ill=%b want pc=%h inst=%h ill=%b",
                               pc_ro, inst_ro, illegal_ro, exp[63:32], exp[31:0], exp_ill);
          end
        end
        if (first_pop < 0) first_pop = c;
        last_pop = c; npop++;
      end
      tick(acc);
    end
    valid_i = 1'b0;
    checks++; if (first_valid != 2) begin errors++; $display("FAIL stream_latency first valid cycle %0d want 2", first_valid); end
    checks++; if (npop != 4 || last_pop - first_pop != 3) begin
      errors++; $display("FAIL stream_back_to_back pops %0d span %0d want 4 span 3", npop, last_pop - first_pop); end
  endtask

  task automatic test_backpressure();
    int k = 0;
    bit was_pop, seen_pop = 0;
    ready_i = 1'b0;
    for (int c = 0; c < 10 && k < 4; c++) begin
      valid_i = 1'b1; pc_i = 32'(k * 4); inst_i = NOP;
      tick(acc); if (acc) k++;
    end
    valid_i = 1'b1; pc_i = 32'd16;
    tick(acc);
    tick(acc);
    checks++; if (count_o !== 3'd4) begin errors++; $display("FAIL bp_count got %0d want 4", count_o); end
    checks++; if (ready_o !== 1'b0 || acc) begin errors++; $display("FAIL bp_ready got %b want 0", ready_o); end
    ready_i = 1'b1;
    for (int c = 0; c < 20 && (sb.size() > 0 || k < 5 || valid_ro); c++) begin
      valid_i = (k < 5); pc_i = 32'(k * 4);
      was_pop = valid_ro && ready_i;
      if (was_pop) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL bp_extra pop pc=%h", pc_ro); end
        else begin
          exp = sb.pop_front(); exp_ill = (exp[1:0] != 2'b11);
          if ({pc_ro, inst_ro, illegal_ro} !== {exp, exp_ill}) begin
            errors++; $display("FAIL bp_order got pc=%h inst=%h want pc=%h inst=%h", pc_ro, inst_ro, exp[63:32], exp[31:0]);
          end
        end
      end
      tick(acc); if (acc) k++;
      if (was_pop && !seen_pop) begin
        seen_pop = 1;
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready_rise got %b want 1", ready_o); end
      end
    end
    valid_i = 1'b0;
    checks++; if (k != 5 || sb.size() != 0 || count_o !== 3'd0) begin
      errors++; $display("FAIL bp_drain pushed %0d left %0d count %0d want 5 0 0", k, sb.size(), count_o); end
  endtask

  task automatic test_flush();
    int k = 0;
    ready_i = 1'b0;
    for (int c = 0; c < 10 && k < 3; c++) begin
      valid_i = 1'b1; pc_i = 32'(100 + k * 4); inst_i = NOP;
      tick(acc); if (acc) k++;
    end
    flush_i = 1'b1; valid_i = 1'b1; pc_i = 32'd40; ready_i = 1'b1;
    tick(acc);
    flush_i = 1'b0; ready_i = 1'b0;
    checks++; if (count_o !== 3'd0 || valid_ro !== 1'b0 || inst_ro !== NOP || illegal_ro !== 1'b0 || ready_o !== 1'b1) begin
      errors++; $display("FAIL flush_state got count=%0d valid=%b inst=%h ill=%b ready=%b want 0 0 %h 0 1",
                         count_o, valid_ro, inst_ro, illegal_ro, ready_o, NOP); end
    tick(acc);
    valid_i = 1'b0;
    checks++; if (!acc) begin errors++; $display("FAIL flush_repush got accepted=%b want 1", acc); end
    tick(acc);
    checks++; if (valid_ro !== 1'b1 || pc_ro !== 32'd40) begin
      errors++; $display("FAIL flush_head got valid=%b pc=%h want 1 00000028", valid_ro, pc_ro); end
    ready_i = 1'b1;
    if (valid_ro && ready_i && sb.size() > 0) exp = sb.pop_front();
    tick(acc);
    ready_i = 1'b0;
  endtask

  task automatic test_full_pop_push();
    int k = 0;
    ready_i = 1'b0;
    for (int c = 0; c < 10 && k < 4; c++) begin
      valid_i = 1'b1; pc_i = 32'(200 + k * 4); inst_i = NOP;
      tick(acc); if (acc) k++;
    end
    tick(acc);
    ready_i = 1'b1; valid_i = 1'b1; pc_i = 32'd216;
    checks++; if (count_o !== 3'd4 || ready_o !== 1'b0) begin
      errors++; $display("FAIL full_state got count=%0d ready=%b want 4 0", count_o, ready_o); end
    if (valid_ro && ready_i && sb.size() > 0) begin
      checks++; exp = sb.pop_front();
      if (pc_ro !== exp[63:32]) begin errors++; $display("FAIL full_pop_pc got %h want %h", pc_ro, exp[63:32]); end
    end
    tick(acc);
    checks++; if (acc || count_o !== 3'd3 || ready_o !== 1'b1) begin
      errors++; $display("FAIL full_pop_no_push got acc=%b count=%0d ready=%b want 0 3 1", acc, count_o, ready_o); end
    ready_i = 1'b0;
    tick(acc);
    valid_i = 1'b0;
    checks++; if (!acc || count_o !== 3'd4) begin
      errors++; $display("FAIL full_next_push got acc=%b count=%0d want 1 4", acc, count_o); end
    ready_i = 1'b1;
    for (int c = 0; c < 12 && sb.size() > 0; c++) begin
      if (valid_ro && ready_i) begin
        checks++; exp = sb.pop_front();
        if ({pc_ro, inst_ro} !== exp) begin
          errors++; $display("FAIL full_order got pc=%h inst=%h want pc=%h inst=%h", pc_ro, inst_ro, exp[63:32], exp[31:0]); end
      end
      tick(acc);
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL full_timeout left %0d want 0", sb.size()); end
    tick(acc);
  endtask

  task automatic test_illegal();
    ready_i = 1'b0;
    valid_i = 1'b1; pc_i = 32'd300; inst_i = 32'h00000001;
    tick(acc);
    pc_i = 32'd304; inst_i = NOP;
    tick(acc);
    valid_i = 1'b0;
    checks++; if (valid_ro !== 1'b1 || illegal_ro !== 1'b1 || pc_ro !== 32'd300) begin
      errors++; $display("FAIL illegal_set got valid=%b ill=%b pc=%h want 1 1 0000012c", valid_ro, illegal_ro, pc_ro); end
    ready_i = 1'b1;
    for (int c = 0; c < 8 && sb.size() > 0; c++) begin
      if (valid_ro && ready_i) begin
        checks++; exp = sb.pop_front(); exp_ill = (exp[1:0] != 2'b11);
        if ({pc_ro, inst_ro, illegal_ro} !== {exp, exp_ill}) begin
          errors++; $display("FAIL illegal_order got pc=%h inst=%h ill=%b want pc=%h inst=%h ill=%b",
                             pc_ro, inst_ro, illegal_ro, exp[63:32], exp[31:0], exp_ill); end
      end
      tick(acc);
    end
    checks++; if (valid_ro !== 1'b0 || inst_ro !== NOP || illegal_ro !== 1'b0) begin
      errors++; $display("FAIL illegal_empty got valid=%b inst=%h ill=%b want 0 %h 0", valid_ro, inst_ro, illegal_ro, NOP); end
  endtask

  task automatic test_reset_midstream();
    int k = 0;
    ready_i = 1'b0;
    for (int c = 0; c < 4 && k < 2; c++) begin
      valid_i = 1'b1; pc_i = 32'(400 + k * 4); inst_i = NOP;
      tick(acc); if (acc) k++;
    end
    tick(acc);
    rst = 1'b0; flush_i = 1'b1; valid_i = 1'b1; ready_i = 1'b1;
    tick(acc);
    rst = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    checks++; if (valid_ro !== 1'b0 || pc_ro !== 32'h0 || inst_ro !== NOP || illegal_ro !== 1'b0 ||
                  count_o !== 3'd0 || ready_o !== 1'b1) begin
      errors++; $display("FAIL midreset got valid=%b pc=%h inst=%h ill=%b count=%0d ready=%b want 0 0 %h 0 0 1",
                         valid_ro, pc_ro, inst_ro, illegal_ro, count_o, ready_o, NOP); end
    k = 0;
    for (int c = 0; c < 30 && (k < 6 || sb.size() > 0); c++) begin
      ready_i = (c >= 4);
      valid_i = (k < 6); pc_i = 32'(500 + k * 4); inst_i = NOP | (32'(k) << 8);
      if (valid_ro && ready_i) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL wrap_extra pop pc=%h", pc_ro); end
        else begin
          exp = sb.pop_front();
          if ({pc_ro, inst_ro} !== exp) begin
            errors++; $display("FAIL wrap_order got pc=%h inst=%h want pc=%h inst=%h", pc_ro, inst_ro, exp[63:32], exp[31:0]); end
        end
      end
      tick(acc); if (acc) k++;
    end
    valid_i = 1'b0;
    checks++; if (k != 6 || sb.size() != 0) begin
      errors++; $display("FAIL wrap_done pushed %0d left %0d want 6 0", k, sb.size()); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_full_pop_push();
    test_illegal();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
